// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: device response and command bytes, host FSM state
// encoding and the frame parity helper.
package ps2_pkg;

  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_SET_LED = 8'hED;
  localparam logic [7:0] PS2_RESET   = 8'hFF;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INHIBIT = 3'd1;
  localparam logic [2:0] RTS     = 3'd2;
  localparam logic [2:0] TX      = 3'd3;
  localparam logic [2:0] ACK     = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data lines, plus a
// one-cycle pulse on each synchronized falling edge of the clock line.
module ps2_line_sync (
  input  logic CLK50MHZ,
  input  logic RST,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic clk_neg
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk};
      data_ff  <= {data_ff[0], ps2_data};
      clk_prev <= clk_ff[1];
    end
  end

  assign data_sync = data_ff[1];
  assign clk_neg   = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host controller: sends command bytes to the keyboard and forwards
// scancodes while idle. Define PS2_CMD_RETRY_EN to resend on FE/timeout/no-ACK.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RETRIES        = 2
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic [7:0] rx_scancode,
  input  logic       rx_ready,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state;
  logic [7:0]    cmd_reg;
  logic          parity;
  logic [3:0]    bitcnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          data_sync;
  logic          clk_neg;
  logic          accept;
  logic          timeout;
  logic          ack_fail;
  logic          resp_fe;
  logic          resp_fa;
  logic          fail;
  logic          retry;

  ps2_line_sync u_line_sync (
    .CLK50MHZ  (CLK50MHZ),
    .RST       (RST),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_sync),
    .clk_neg   (clk_neg)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready;

  // A timeout outranks a same-cycle FA so done and err never both fire
  assign timeout  = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign ack_fail = (state == ACK) && clk_neg && data_sync;
  assign resp_fe  = (state == RESP) && rx_ready && (rx_scancode == PS2_RESEND);
  assign resp_fa  = (state == RESP) && rx_ready && (rx_scancode == PS2_ACK) && !timeout;
  assign fail     = timeout | ack_fail | resp_fe;

`ifdef PS2_CMD_RETRY_EN
  localparam int RW = $clog2(RETRIES + 2);
  logic [RW-1:0] retry_cnt;

  assign retry = fail && (retry_cnt < RW'(RETRIES));

  always_ff @(posedge CLK50MHZ) begin
    if (RST)        retry_cnt <= '0;
    else if (accept) retry_cnt <= '0;
    else if (retry)  retry_cnt <= retry_cnt + 1'b1;
  end
`else
  logic unused_retries;
  assign unused_retries = ^RETRIES;
  assign retry          = 1'b0;
`endif

  // Command sequencer; clk_oe rises on acceptance so it is low-held for
  // exactly INHIBIT_CYCLES before the one-cycle RTS with data pulled low
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      key_code    <= 8'h00;
      key_valid   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cmd_reg     <= 8'h00;
      parity      <= 1'b0;
      bitcnt      <= 4'd0;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
    end else begin
      key_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      if (state != IDLE) tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (rx_ready) begin
            key_code  <= rx_scancode;
            key_valid <= 1'b1;
          end
          if (accept) begin
            cmd_reg    <= cmd_byte;
            parity     <= odd_parity(cmd_byte);
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        RTS: begin
          bitcnt <= 4'd0;
          state  <= TX;
        end
        TX: begin
          if (clk_neg) begin
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt < 4'd8) begin
              ps2_data_oe <= ~cmd_reg[bitcnt[2:0]];
            end else if (bitcnt == 4'd8) begin
              ps2_data_oe <= ~parity;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end
        end
        ACK: begin
          if (clk_neg && !data_sync) state <= RESP;
        end
        RESP: begin
          if (resp_fa) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (fail) begin
        ps2_data_oe <= 1'b0;
        inh_cnt     <= '0;
        tmo_cnt     <= '0;
        if (retry) begin
          ps2_clk_oe <= 1'b1;
          state      <= INHIBIT;
        end else begin
          ps2_clk_oe <= 1'b0;
          err        <= 1'b1;
          state      <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl with a simple PS/2 keyboard line model;
// expectations adapt when PS2_CMD_RETRY_EN is defined.
module tb_ps2_host_ctrl;
  import ps2_pkg::*;

  localparam int INH  = 5000;
  localparam int TMO  = 6000;
  localparam int RETR = 2;
  localparam int HALF = 15;
`ifdef PS2_CMD_RETRY_EN
  localparam int ATTEMPTS = RETR + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       CLK50MHZ = 1'b0;
  logic       RST = 1'b1;
  wire        ps2_clk;
  wire        ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_ready;
  logic [7:0] rx_scancode = 8'h00;
  logic       rx_ready = 1'b0;
  logic [7:0] key_code;
  logic       key_valid;
  logic       done;
  logic       err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  assign ps2_clk  = ps2_clk_oe  ? 1'b0 : dev_clk;
  assign ps2_data = ps2_data_oe ? 1'b0 : dev_data;

  always #10 CLK50MHZ = ~CLK50MHZ;
  always @(posedge CLK50MHZ) cyc <= cyc + 1;

  ps2_host_ctrl #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .RETRIES        (RETR)
  ) dut (
    .CLK50MHZ    (CLK50MHZ),
    .RST         (RST),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .cmd_ready   (cmd_ready),
    .rx_scancode (rx_scancode),
    .rx_ready    (rx_ready),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .done        (done),
    .err         (err),
    .busy        (busy)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge CLK50MHZ);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    @(negedge CLK50MHZ);
    cmd_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge CLK50MHZ);
    rx_scancode = b;
    rx_ready    = 1'b1;
    @(negedge CLK50MHZ);
    rx_ready = 1'b0;
  endtask

  task automatic measure_inhibit(output int n);
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < INH + 100) begin
      n++;
      @(negedge CLK50MHZ);
    end
  endtask

  task automatic dev_wait_rts();
    int n = 0;
    while (!(ps2_data === 1'b0 && ps2_clk_oe === 1'b0) && n < INH + 200) begin
      @(negedge CLK50MHZ);
      n++;
    end
    check_output("rts_seen", 32'(ps2_data === 1'b0 && ps2_clk_oe === 1'b0), 1);
    repeat (10) @(negedge CLK50MHZ);
  endtask

  // Device clocks n pulses, sampling the data line on each rising edge
  task automatic dev_clock(input int n, output logic [9:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLK50MHZ);
      dev_clk = 1'b1;
      bits[i] = ps2_data;
      repeat (HALF) @(negedge CLK50MHZ);
    end
  endtask

  task automatic dev_ack_edge(input logic ack);
    dev_data = ack ? 1'b0 : 1'b1;
    repeat (5) @(negedge CLK50MHZ);
    dev_clk = 1'b0;
  endtask

  task automatic dev_release();
    repeat (HALF) @(negedge CLK50MHZ);
    dev_clk = 1'b1;
    repeat (3) @(negedge CLK50MHZ);
    dev_data = 1'b1;
  endtask

  task automatic wait_err(input int bound, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge CLK50MHZ);
      if (err === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    logic [9:0] bits;
    logic       seen;
    int         n;
    int         t0;
    int         t1;

    // Reset state
    repeat (3) @(negedge CLK50MHZ);
    check_output("rst_cmd_ready", cmd_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_clk_oe", ps2_clk_oe, 0);
    check_output("rst_data_oe", ps2_data_oe, 0);
    check_output("rst_key_valid", key_valid, 0);
    check_output("rst_key_code", key_code, 8'h00);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    RST = 1'b0;
    @(negedge CLK50MHZ);

    // Idle scancode forwarding
    send_rx(8'h1C);
    check_output("idle_key_valid", key_valid, 1);
    check_output("idle_key_code", key_code, 8'h1C);
    check_output("idle_busy", busy, 0);
    @(negedge CLK50MHZ);
    check_output("idle_key_valid_pulse", key_valid, 0);

    // ED command, ACKed and answered with FA
    send_cmd(PS2_SET_LED);
    check_output("ed_busy", busy, 1);
    check_output("ed_cmd_ready", cmd_ready, 0);
    measure_inhibit(n);
    check_output("ed_inhibit_len", n, INH);
    dev_wait_rts();
    dev_clock(10, bits);
    check_output("ed_bits", 32'(bits), 10'h3ED);
    dev_ack_edge(1'b1);
    dev_release();
    check_output("ed_resp_busy", busy, 1);
    send_rx(8'hAA);
    check_output("ed_other_not_fwd", key_valid, 0);
    check_output("ed_other_busy", busy, 1);
    check_output("ed_other_done", done, 0);
    send_rx(PS2_ACK);
    check_output("ed_done", done, 1);
    check_output("ed_fa_not_fwd", key_valid, 0);
    check_output("ed_busy_fall", busy, 0);
    check_output("ed_ready", cmd_ready, 1);
    @(negedge CLK50MHZ);
    check_output("ed_done_pulse", done, 0);

    // F4 answered with FE (resends when retry is built in)
    send_cmd(8'hF4);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_wait_rts();
      dev_clock(10, bits);
      check_output("f4_bits", 32'(bits), 10'h2F4);
      dev_ack_edge(1'b1);
      dev_release();
      if (a < ATTEMPTS - 1) begin
        send_rx(PS2_RESEND);
        check_output("f4_resend_err", err, 0);
        check_output("f4_resend_busy", busy, 1);
        check_output("f4_resend_inhibit", ps2_clk_oe, 1);
      end else begin
`ifdef PS2_CMD_RETRY_EN
        send_rx(PS2_ACK);
        check_output("f4_final_done", done, 1);
        check_output("f4_final_err", err, 0);
`else
        send_rx(PS2_RESEND);
        check_output("f4_err", err, 1);
        check_output("f4_done", done, 0);
        check_output("f4_clk_oe", ps2_clk_oe, 0);
        check_output("f4_data_oe", ps2_data_oe, 0);
`endif
        check_output("f4_busy", busy, 0);
      end
    end

    // Scancode coinciding with acceptance, then device never clocks
    @(negedge CLK50MHZ);
    cmd_valid   = 1'b1;
    cmd_byte    = PS2_SET_LED;
    rx_ready    = 1'b1;
    rx_scancode = 8'h5A;
    @(negedge CLK50MHZ);
    cmd_valid = 1'b0;
    rx_ready  = 1'b0;
    t0 = cyc;
    check_output("both_key_valid", key_valid, 1);
    check_output("both_key_code", key_code, 8'h5A);
    check_output("both_busy", busy, 1);
    wait_err(TMO * ATTEMPTS + 100, seen);
    t1 = cyc;
    check_output("tmo_err_seen", seen, 1);
    check_output("tmo_latency", t1 - t0, TMO * ATTEMPTS);
    check_output("tmo_clk_oe", ps2_clk_oe, 0);
    check_output("tmo_data_oe", ps2_data_oe, 0);
    check_output("tmo_busy", busy, 0);

    // FF with no line ACK
    send_cmd(PS2_RESET);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_wait_rts();
      dev_clock(10, bits);
      check_output("ff_bits", 32'(bits), 10'h3FF);
      dev_ack_edge(1'b0);
      wait_err(20, seen);
      check_output("noack_err", seen, 32'(a == ATTEMPTS - 1));
      if (a == ATTEMPTS - 1) begin
        check_output("noack_clk_oe", ps2_clk_oe, 0);
        check_output("noack_data_oe", ps2_data_oe, 0);
        check_output("noack_busy", busy, 0);
      end
      dev_release();
    end

    // Reset in the middle of transmission, bit 4 of ED on the line
    send_cmd(PS2_SET_LED);
    dev_wait_rts();
    dev_clock(5, bits);
    check_output("tx_bit4_data_oe", ps2_data_oe, 1);
    RST = 1'b1;
    @(negedge CLK50MHZ);
    check_output("mid_rst_clk_oe", ps2_clk_oe, 0);
    check_output("mid_rst_data_oe", ps2_data_oe, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_cmd_ready", cmd_ready, 1);
    RST = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK50MHZ);
      if (done === 1'b1 || err === 1'b1) seen = 1'b1;
    end
    check_output("mid_rst_no_strobe", seen, 0);
    check_output("mid_rst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
